// File: rtl/cache_controller.sv
// Sequencing FSM for a direct-mapped, write-through, no-write-allocate data cache.
// Serialises one CPU access at a time, refills on load miss, and counts hits/misses.
module cache_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req_i,
  input  logic                  cpu_we_i,
  input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
  input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
  output logic [DATA_WIDTH-1:0] cpu_rdata_o,
  output logic                  cpu_done_o,
  output logic                  stall_o,
  output logic [ADDR_WIDTH-1:0] cache_addr_o,
  output logic                  cache_we_o,
  output logic [DATA_WIDTH-1:0] cache_wdata_o,
  input  logic [DATA_WIDTH-1:0] cache_rdata_i,
  input  logic                  cache_hit_i,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  input  logic                  mem_ready_i,
  output logic [CNT_WIDTH-1:0]  hit_count_o,
  output logic [CNT_WIDTH-1:0]  miss_count_o
);

  typedef enum logic [2:0] {IDLE, LOOKUP, MEM_RD, FILL, MEM_WR, RESPOND} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] fill_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [CNT_WIDTH-1:0]  hit_cnt;
  logic [CNT_WIDTH-1:0]  miss_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr_q   <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      fill_q   <= '0;
      rdata_q  <= '0;
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (cpu_req_i) begin
          addr_q  <= cpu_addr_i;
          we_q    <= cpu_we_i;
          wdata_q <= cpu_wdata_i;
          state   <= LOOKUP;
        end
        LOOKUP: begin
          if (cache_hit_i) begin
            if (hit_cnt != '1) hit_cnt <= hit_cnt + CNT_WIDTH'(1);
          end else begin
            if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_WIDTH'(1);
          end
          if (we_q) state <= MEM_WR;
          else if (cache_hit_i) begin
            rdata_q <= cache_rdata_i;
            state   <= RESPOND;
          end else state <= MEM_RD;
        end
        MEM_RD: if (mem_ready_i) begin
          rdata_q <= mem_rdata_i;
          fill_q  <= mem_rdata_i;
          state   <= FILL;
        end
        FILL:    state <= RESPOND;
        MEM_WR:  if (mem_ready_i) state <= RESPOND;
        RESPOND: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Store-hit update must land in the lookup cycle, so it follows cache_hit_i directly.
  assign cache_we_o    = (state == FILL) || ((state == LOOKUP) && we_q && cache_hit_i);
  assign cache_addr_o  = addr_q;
  assign cache_wdata_o = (state == FILL) ? fill_q : wdata_q;

  assign mem_req_o   = (state == MEM_RD) || (state == MEM_WR);
  assign mem_we_o    = (state == MEM_WR);
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  assign cpu_done_o   = (state == RESPOND);
  assign stall_o      = (state == LOOKUP) || (state == MEM_RD) || (state == FILL) || (state == MEM_WR);
  assign cpu_rdata_o  = rdata_q;
  assign hit_count_o  = hit_cnt;
  assign miss_count_o = miss_cnt;

endmodule

// File: tb/tb_cache_controller.sv
// Bench for cache_controller: a direct-mapped cache array and a wait-state memory surround the
// controller; each access is predicted from those arrays and the access rules.
module tb_cache_controller;
  localparam int CW = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req_i = 1'b0, cpu_we_i = 1'b0;
  logic [31:0] cpu_addr_i = '0, cpu_wdata_i = '0;
  logic [31:0] cpu_rdata_o;
  logic        cpu_done_o, stall_o;
  logic [31:0] cache_addr_o, cache_wdata_o, cache_rdata_i;
  logic        cache_we_o, cache_hit_i;
  logic        mem_req_o, mem_we_o, mem_ready_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic [CW-1:0] hit_count_o, miss_count_o;

  cache_controller #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
    .cpu_rdata_o(cpu_rdata_o), .cpu_done_o(cpu_done_o), .stall_o(stall_o),
    .cache_addr_o(cache_addr_o), .cache_we_o(cache_we_o), .cache_wdata_o(cache_wdata_o),
    .cache_rdata_i(cache_rdata_i), .cache_hit_i(cache_hit_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
    .hit_count_o(hit_count_o), .miss_count_o(miss_count_o)
  );

  always #5 clk = ~clk;

  // Environment: 16-line cache (index addr[5:2], tag addr[9:6]) and 256-word memory.
  logic        cvalid [16];
  logic [3:0]  ctags  [16];
  logic [31:0] cdata  [16];
  logic [31:0] mem    [256];
  logic        env_init = 1'b0;
  int          ws_target = 0;
  int          wait_cnt = 0;
  int          cwe_cnt = 0, mwr_cnt = 0, mreq_cnt = 0, addr_moves = 0;
  logic        mreq_prev = 1'b0;
  logic [31:0] addr_prev = '0;
  logic        poke_en = 1'b0;
  logic [7:0]  poke_idx = '0;
  logic [31:0] poke_data = '0;

  assign cache_hit_i   = cvalid[cache_addr_o[5:2]] && (ctags[cache_addr_o[5:2]] == cache_addr_o[9:6]);
  assign cache_rdata_i = cdata[cache_addr_o[5:2]];
  assign mem_rdata_i   = mem[mem_addr_o[9:2]];
  assign mem_ready_i   = mem_req_o && (wait_cnt == ws_target);

  always @(posedge clk) begin
    if (!env_init) begin
      for (int i = 0; i < 16; i++) begin cvalid[i] <= 1'b0; ctags[i] <= '0; cdata[i] <= '0; end
      for (int i = 0; i < 256; i++) mem[i] <= $urandom;
      env_init <= 1'b1;
    end else begin
      if (poke_en) mem[poke_idx] <= poke_data;
      if (cache_we_o) begin
        cvalid[cache_addr_o[5:2]] <= 1'b1;
        ctags[cache_addr_o[5:2]]  <= cache_addr_o[9:6];
        cdata[cache_addr_o[5:2]]  <= cache_wdata_o;
        cwe_cnt <= cwe_cnt + 1;
      end
      if (mem_req_o && mem_we_o && mem_ready_i) begin
        mem[mem_addr_o[9:2]] <= mem_wdata_o;
        mwr_cnt <= mwr_cnt + 1;
      end
    end
    if (mem_req_o) begin
      mreq_cnt <= mreq_cnt + 1;
      wait_cnt <= mem_ready_i ? 0 : wait_cnt + 1;
      if (mreq_prev && (mem_addr_o !== addr_prev)) addr_moves <= addr_moves + 1;
    end else wait_cnt <= 0;
    mreq_prev <= mem_req_o;
    addr_prev <= mem_addr_o;
  end

  int          nvec = 0, nfail = 0;
  int          exp_hits = 0, exp_misses = 0;
  logic [31:0] exp_rdata = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete CPU access; expectations come from the environment arrays before the access.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input int ws, input string tag);
    logic hit;
    int exp_lat, k, stall_err, c0, w0, r0, a0;
    hit = cvalid[addr[5:2]] && (ctags[addr[5:2]] == addr[9:6]);
    exp_lat = we ? 3 + ws : (hit ? 2 : 4 + ws);
    if (!we) exp_rdata = mem[addr[9:2]];
    if (hit) exp_hits = (exp_hits == (1 << CW) - 1) ? exp_hits : exp_hits + 1;
    else     exp_misses = (exp_misses == (1 << CW) - 1) ? exp_misses : exp_misses + 1;
    c0 = cwe_cnt; w0 = mwr_cnt; r0 = mreq_cnt; a0 = addr_moves;
    @(posedge clk); #1;
    ws_target = ws;
    cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wd; cpu_req_i = 1'b1;
    @(posedge clk); #1;
    k = 1; stall_err = 0;
    while (!cpu_done_o && k < 40) begin
      if (stall_o !== 1'b1) stall_err++;
      @(posedge clk); #1;
      k++;
    end
    cpu_req_i = 1'b0;
    if (stall_o !== 1'b0) stall_err++;
    chk({tag, "_latency"}, k, exp_lat);
    chk({tag, "_rdata"}, cpu_rdata_o, exp_rdata);
    chk({tag, "_hits"}, 32'(hit_count_o), exp_hits);
    chk({tag, "_misses"}, 32'(miss_count_o), exp_misses);
    chk({tag, "_cache_writes"}, cwe_cnt - c0, (we == hit) ? 1 : 0);
    chk({tag, "_mem_writes"}, mwr_cnt - w0, we ? 1 : 0);
    chk({tag, "_mem_req_cycles"}, mreq_cnt - r0, (!we && hit) ? 0 : ws + 1);
    chk({tag, "_stall"}, stall_err, 0);
    chk({tag, "_mem_addr_stable"}, addr_moves - a0, 0);
    if (we) chk({tag, "_mem_data"}, mem[addr[9:2]], wd);
    if (we && hit) chk({tag, "_cache_data"}, cdata[addr[5:2]], wd);
    if (!we && !hit) chk({tag, "_fill_data"}, cdata[addr[5:2]], exp_rdata);
  endtask

  initial begin
    int c0;
    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", cpu_rdata_o, 0);
    chk("rst_done", cpu_done_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_cache_we", cache_we_o, 0);
    chk("rst_counts", {hit_count_o, miss_count_o}, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    rst_n = 1'b1;
    poke_en = 1'b1; poke_idx = 8'h10; poke_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    poke_en = 1'b0;

    do_access(1'b0, 32'h40, 32'h0, 0, "load_miss");
    chk("load_miss_value", cpu_rdata_o, 32'hDEADBEEF);
    do_access(1'b0, 32'h40, 32'h0, 0, "load_hit");
    do_access(1'b1, 32'h40, 32'h12345678, 0, "store_hit");
    chk("store_keeps_rdata", cpu_rdata_o, 32'hDEADBEEF);
    do_access(1'b1, 32'h80, 32'hCAFEF00D, 1, "store_miss");
    do_access(1'b0, 32'h100, 32'h0, 3, "load_wait3");

    // reset while a refill is outstanding
    @(posedge clk); #1;
    ws_target = 100;
    c0 = cwe_cnt;
    cpu_we_i = 1'b0; cpu_addr_i = 32'h200; cpu_req_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrefill_req_before", mem_req_o, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrefill_req_dropped", mem_req_o, 0);
    chk("midrefill_no_done", cpu_done_o, 0);
    chk("midrefill_stall", stall_o, 0);
    chk("midrefill_counts", {hit_count_o, miss_count_o}, 0);
    chk("midrefill_rdata", cpu_rdata_o, 0);
    chk("midrefill_no_cache_write", cwe_cnt - c0, 0);
    cpu_req_i = 1'b0;
    rst_n = 1'b1;
    exp_hits = 0; exp_misses = 0; exp_rdata = '0;

    // saturation: five conflicting misses on line 0
    for (int i = 0; i < 5; i++) do_access(1'b0, 32'(i) << 6, 32'h0, 0, "sat_miss");
    chk("sat_final", 32'(miss_count_o), 3);

    // random mix over 32 words so lines are reused and hit often
    for (int i = 0; i < 60; i++)
      do_access(1'($urandom_range(0, 1)), 32'($urandom_range(0, 31)) << 2, $urandom,
                int'($urandom_range(0, 3)), "rand");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cache_controller.md
# cache_controller

Sequencing controller for the direct-mapped data cache. Accepts one CPU load/store at a time, performs the cache lookup, refills the cache from main memory on a read miss, and writes through to memory on every store. It sits between the CPU memory stage and the `direct_mapped_cache` / data-memory pair. It stalls the CPU until each access completes and keeps hit/miss statistics.

## Interface
- `DATA_WIDTH`, 32, data word width
- `ADDR_WIDTH`, 32, byte address width
- `CNT_WIDTH`, 16, width of hit/miss counters
- Clocking: one clock `clk`; reset `rst_n` is synchronous and active-low.
- `clk`  in  1  clock; all state updates on rising edge
- `rst_n`  in  1  synchronous active-low reset
- `cpu_req_i`  in  1  access request; held by CPU until `cpu_done_o`
- `cpu_we_i`  in  1  1 = store, 0 = load
- `cpu_addr_i`  in  ADDR_WIDTH  access address
- `cpu_wdata_i`  in  DATA_WIDTH  store data
- `cpu_rdata_o`  out  DATA_WIDTH  load result, registered
- `cpu_done_o`  out  1  one-cycle completion pulse
- `stall_o`  out  1  CPU must hold pipeline
- `cache_addr_o`  out  ADDR_WIDTH  lookup/update address
- `cache_we_o`  out  1  cache line write strobe
- `cache_wdata_o`  out  DATA_WIDTH  cache write data
- `cache_rdata_i`  in  DATA_WIDTH  cache read data, combinational from `cache_addr_o`
- `cache_hit_i`  in  1  cache hit, combinational from `cache_addr_o`
- `mem_req_o`  out  1  memory request
- `mem_we_o`  out  1  memory write
- `mem_addr_o`  out  ADDR_WIDTH  memory address
- `mem_wdata_o`  out  DATA_WIDTH  memory write data
- `mem_rdata_i`  in  DATA_WIDTH  memory read data, valid with `mem_ready_i`
- `mem_ready_i`  in  1  memory completes current request
- `hit_count_o`  out  CNT_WIDTH  saturating lookup-hit count
- `miss_count_o`  out  CNT_WIDTH  saturating lookup-miss count

## Operation
- States: IDLE, LOOKUP, MEM_RD, FILL, MEM_WR, RESPOND.
- IDLE:
  - When `cpu_req_i` = 1, latch addr/we/wdata into request registers and go to LOOKUP.
  - `cpu_req_i` is ignored in every other state.
- LOOKUP: `cache_addr_o` = latched addr; sample `cache_hit_i`.
  - Load hit: capture `cache_rdata_i` into `cpu_rdata_o`, go to RESPOND.
  - Load miss: go to MEM_RD.
  - Store hit: assert `cache_we_o` this cycle with `cache_wdata_o` = latched wdata (cache update), go to MEM_WR.
  - Store miss: no allocate, go to MEM_WR.
  - Increment `hit_count_o` or `miss_count_o` for both loads and stores. Counters saturate at all-ones and do not wrap.
- MEM_RD:
  - `mem_req_o` = 1, `mem_we_o` = 0, `mem_addr_o` = latched addr.
  - On `mem_ready_i` = 1: capture `mem_rdata_i` into `cpu_rdata_o` and the fill register, go to FILL. Otherwise remain.
- FILL: `cache_we_o` = 1, `cache_addr_o` = latched addr, `cache_wdata_o` = fill register; go to RESPOND.
- MEM_WR:
  - `mem_req_o` = 1, `mem_we_o` = 1, `mem_wdata_o` = latched wdata.
  - On `mem_ready_i` go to RESPOND.
- RESPOND: `cpu_done_o` = 1; go to IDLE.
- `stall_o` = 1 in LOOKUP, MEM_RD, FILL, MEM_WR; 0 in IDLE and RESPOND.
- `mem_*` address/data outputs hold stable for the whole time `mem_req_o` is high. `mem_ready_i` is ignored when `mem_req_o` = 0.
- `cache_we_o` is 0 outside LOOKUP (store hit) and FILL.
- `cpu_rdata_o` holds its value until the next load completes; stores leave it unchanged.

## Timing
- Reset (`rst_n` = 0 at an edge):
  - State becomes IDLE.
  - All outputs become 0, including counters, `cpu_rdata_o`, and request registers.
  - Applies mid-operation: an in-flight memory request is dropped (`mem_req_o` low the cycle after the reset edge), with no `cpu_done_o` and no cache write.
- Accept edge = edge at which IDLE sees `cpu_req_i`. `cpu_done_o` latency from the accept edge:
  - Load hit: high during the 2nd cycle after accept.
  - Load miss: 4 + N cycles, N = cycles `mem_ready_i` is withheld.
  - Store hit or miss: 3 + N cycles.
- Back-to-back: a new request is accepted no earlier than the IDLE cycle following RESPOND, giving a minimum 3-cycle spacing between accepts.
- Counters are updated at the edge leaving LOOKUP and are visible the cycle after.
- Memory handshake: request completes in the cycle `mem_req_o` && `mem_ready_i`; `mem_req_o` deasserts the next cycle.

## Test plan
- Reset then load miss: reset, load addr 0x40, mem returns 0xDEADBEEF with ready on first MEM_RD cycle -> `cache_we_o` pulse in FILL with 0xDEADBEEF, `cpu_done_o` 4 cycles after accept, `cpu_rdata_o` = 0xDEADBEEF, `miss_count_o` = 1.
- Load hit: repeat load 0x40 with cache model reporting hit -> `cpu_done_o` 2 cycles after accept, no `mem_req_o`, `hit_count_o` = 1.
- Store hit and store miss:
  - Store 0x12345678 to 0x40 (hit) -> `cache_we_o` in LOOKUP, memory write with data 0x12345678, done at 3 cycles, `cpu_rdata_o` unchanged.
  - Store to 0x80 (miss) -> no `cache_we_o`, memory write only.
- Memory wait states: load miss with `mem_ready_i` withheld 3 cycles -> `stall_o` high throughout, `mem_addr_o` stable, done at 7 cycles.
- Reset mid-refill: assert `rst_n` = 0 during MEM_RD -> `mem_req_o` = 0 next cycle, no `cpu_done_o`, no cache write, counters = 0.
- Saturation: with `CNT_WIDTH` = 2, perform 5 misses -> `miss_count_o` stays 3.
